shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Sequential controller that sits directly in front of the team's 4-bit combinational shifter unit. It holds the working register and drives the shifter's select, data and fill-bit inputs. Each cycle it latches the shifter's result back into the register, so one accepted command runs a shift or rotate operation for a programmed number of steps. Command intake uses a valid/ready handshake, and a one-cycle `done` pulse marks completion.

## Interface
- `CNT_W`, default 4: width of the step-count field. The maximum count is 2^CNT_W−1.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block can accept a command. High only in IDLE.
- `cmd_load` in 1: load `cmd_data` into the register before stepping.
- `cmd_data` in 4: load value.
- `cmd_op` in 3: shifter operation code, latched on accept.
- `cmd_count` in CNT_W: number of shifter steps to run.
- `ser_in_right` in 1: fill bit for shift-left. Drives `sh_ir`.
- `ser_in_left` in 1: fill bit for shift-right. Drives `sh_il`.
- `sh_select` out 3: select input to the shifter.
- `sh_data` out 4: data input to the shifter. Always equals `reg_q`.
- `sh_ir`, `sh_il` out 1 each: combinational pass-through of `ser_in_right` and `ser_in_left`.
- `sh_exit` in 4: combinational result from the shifter.
- `reg_q` out 4: working register.
- `ser_out_msb`, `ser_out_lsb` out 1 each: `reg_q[3]` and `reg_q[0]`.
- `busy` out 1: high in RUN or DONE.
- `done` out 1: one-cycle completion pulse.

## Operation
- Op encoding, shared with the shifter:
  - 000: hold.
  - 001: shift left. `sh_ir` enters the LSB.
  - 010: shift right. `sh_il` enters the MSB.
  - 011: clear.
  - 101: rotate left.
  - 110: rotate right.
  - 100 and 111: hold. Still consume the full step count; no error is flagged.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `cmd_ready`=1, `sh_select`=000.
  - A command is accepted on a clock edge where `cmd_valid`&`cmd_ready`.
  - On accept:
    - Latch `cmd_op`.
    - Set `remaining`=`cmd_count`.
    - If `cmd_load`=1, set `reg_q`←`cmd_data`; otherwise `reg_q` is unchanged.
    - Next state is RUN if `cmd_count`≠0, else DONE.
- RUN:
  - `sh_select`=latched op.
  - Every edge: `reg_q`←`sh_exit` and `remaining`←`remaining`−1.
  - When `remaining`==1 at the edge, go to DONE.
  - Inputs are not sampled except `ser_in_*`, which are live every step.
- DONE:
  - `done`=1, `sh_select`=000, `reg_q` holds.
  - The next edge returns to IDLE unconditionally.
- `remaining` never wraps. A count of 0 bypasses RUN.
- Outside RUN, `reg_q` changes only on a load accept.

## Timing
- Reset values:
  - state=IDLE, `reg_q`=0000, `remaining`=0, latched op=000.
  - `done`=0, `busy`=0, `cmd_ready`=1, `sh_select`=000, `ser_out_*`=0.
- `cmd_ready` is decoded from state, so it reads 1 during reset. No command is accepted while `rst_n`=0.
- Accept at edge E0, count N≥1:
  - RUN occupies the cycles after edges E0…E(N−1). Step k updates `reg_q` at edge Ek.
  - DONE (`done`=1, final `reg_q`) is in the cycle after EN.
  - IDLE (`cmd_ready`=1) resumes after E(N+1).
  - Command-to-command throughput is N+2 cycles.
- Count 0: DONE in the cycle after E0, with the loaded value visible. Throughput is 2 cycles.
- `cmd_valid` is ignored outside IDLE. An initiator must hold the command until it sees `cmd_ready`.
- Reset asserted mid-RUN or mid-DONE:
  - The block returns to reset values immediately.
  - A `done` in progress is dropped.
  - The partially shifted `reg_q` is lost.
- `sh_exit` must settle within the cycle. The loop `reg_q`→shifter→`reg_q` is a single-cycle path with no combinational loop inside this block.

## Test plan
- Load `cmd_data`=1011 with op 101, count 1 → `reg_q`=0111, `done` 2 cycles after accept. Repeat with count 4 → 1011, `done` 5 cycles after accept.
- Load 1011 with op 001, count 2, `ser_in_right`=1 → `reg_q` steps 0111 then 1111; `ser_out_msb`=1 at DONE.
- Load 1000 with op 010, count 3, `ser_in_left`=0 → 0100, 0010, 0001; `ser_out_lsb`=1. Follow with op 110, count 1, no load → 1000.
- Load 0110 with count 0 → `reg_q`=0110 and `done` in the first cycle after accept; no step taken. Then op 011, count 1, no load → 0000.
- Op 111, count 3 on 1010 → `reg_q` stays 1010, `busy` for 4 cycles. `cmd_valid` held high during busy is not accepted until IDLE.
- Load 1111 with op 001, count 15; deassert `rst_n` at step 5:
  - Immediately `reg_q`=0000, `busy`=0, `done` never pulses.
  - After release, a new command is accepted on the first edge.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences a 4-bit external combinational shifter.
// Holds the working register, drives the shifter select/data/fill inputs and
// writes the shifter result back once per step for the accepted step count.
module shift_sequencer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [3:0]       cmd_data,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             ser_in_right,
  input  logic             ser_in_left,
  output logic [2:0]       sh_select,
  output logic [3:0]       sh_data,
  output logic             sh_ir,
  output logic             sh_il,
  input  logic [3:0]       sh_exit,
  output logic [3:0]       reg_q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       reg_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Next-state, step counter and working-register update.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    op_d        = op_q;
    reg_d       = reg_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          remaining_d = cmd_count;
          if (cmd_load) reg_d = cmd_data;
          state_d = (cmd_count != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        reg_d = sh_exit;
        // Guard keeps the counter from wrapping even if it were ever 0 here.
        if (remaining_q != '0) remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q <= CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      op_q        <= '0;
      reg_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Output decode: ready and select come straight from the current state.
  always_comb begin
    cmd_ready   = (state_q == IDLE);
    sh_select   = (state_q == RUN) ? op_q : 3'b000;
    sh_data     = reg_q;
    sh_ir       = ser_in_right;
    sh_il       = ser_in_left;
    ser_out_msb = reg_q[3];
    ser_out_lsb = reg_q[0];
    busy        = busy_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vectors with hand-computed results; the
// external 4-bit shifter is modelled here from the shared op encoding.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [3:0] cmd_data = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_count = '0;
  logic       ser_in_right = 1'b0;
  logic       ser_in_left = 1'b0;
  logic [2:0] sh_select;
  logic [3:0] sh_data;
  logic       sh_ir, sh_il;
  logic [3:0] sh_exit;
  logic [3:0] reg_q;
  logic       ser_out_msb, ser_out_lsb;
  logic       busy, done;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] trace [0:40];
  int lat, bcyc;

  shift_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_data(cmd_data), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .ser_in_right(ser_in_right), .ser_in_left(ser_in_left),
    .sh_select(sh_select), .sh_data(sh_data), .sh_ir(sh_ir), .sh_il(sh_il),
    .sh_exit(sh_exit), .reg_q(reg_q),
    .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External shifter model.
  always_comb begin
    case (sh_select)
      3'b001:  sh_exit = {sh_data[2:0], sh_ir};
      3'b010:  sh_exit = {sh_il, sh_data[3:1]};
      3'b011:  sh_exit = 4'b0000;
      3'b101:  sh_exit = {sh_data[2:0], sh_data[3]};
      3'b110:  sh_exit = {sh_data[0], sh_data[3:1]};
      default: sh_exit = sh_data;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command and follow it to done. lat = edges after the accept
  // edge until done is seen; trace[k] = reg_q after edge k (0 = accept edge).
  // With hold_valid, a second command (load 0101, count 0) is left pending.
  task automatic run_cmd(input logic ld, input logic [3:0] data, input logic [2:0] op,
                         input logic [3:0] cnt, input logic hold_valid,
                         output int lat_o, output int busy_o);
    int w;
    @(negedge clk);
    cmd_load = ld; cmd_data = data; cmd_op = op; cmd_count = cnt; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", (w < 50) ? 1 : 0, 1);
    @(posedge clk); #1;
    if (hold_valid) begin
      cmd_load = 1'b1; cmd_data = 4'b0101; cmd_op = 3'b000; cmd_count = 4'd0;
    end else begin
      cmd_valid = 1'b0;
    end
    lat_o = 0; busy_o = 0;
    trace[0] = reg_q;
    while (!done && lat_o < 40) begin
      if (busy) busy_o++;
      @(posedge clk); #1;
      lat_o++;
      trace[lat_o] = reg_q;
    end
    if (busy) busy_o++;
    chk("done_seen", {31'b0, done}, 1);
  endtask

  task automatic after_done;
    @(posedge clk); #1;
    chk("done_pulse_len", {31'b0, done}, 0);
    chk("ready_back", {31'b0, cmd_ready}, 1);
  endtask

  initial begin
    // Reset values while rst_n is low.
    #1;
    chk("rst_reg", {28'b0, reg_q}, 0);
    chk("rst_ready", {31'b0, cmd_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_sel", {29'b0, sh_select}, 0);
    chk("rst_msb_lsb", {30'b0, ser_out_msb, ser_out_lsb}, 0);
    // Command presented during reset must not be accepted.
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'b1001; cmd_count = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_accept", {28'b0, reg_q}, 0);
    cmd_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Rotate left 1011, count 1 -> 0111.
    run_cmd(1'b1, 4'b1011, 3'b101, 4'd1, 1'b0, lat, bcyc);
    chk("rotl1_reg", {28'b0, reg_q}, 4'b0111);
    chk("rotl1_lat", lat, 1);
    chk("rotl1_sel_idle", {29'b0, sh_select}, 0);
    after_done();
    // Rotate left 1011, count 4 -> 1011.
    run_cmd(1'b1, 4'b1011, 3'b101, 4'd4, 1'b0, lat, bcyc);
    chk("rotl4_reg", {28'b0, reg_q}, 4'b1011);
    chk("rotl4_step2", {28'b0, trace[2]}, 4'b1110);
    chk("rotl4_lat", lat, 4);
    after_done();

    // Shift left with ir=1: 1011 -> 0111 -> 1111.
    ser_in_right = 1'b1;
    run_cmd(1'b1, 4'b1011, 3'b001, 4'd2, 1'b0, lat, bcyc);
    chk("shl_step1", {28'b0, trace[1]}, 4'b0111);
    chk("shl_step2", {28'b0, trace[2]}, 4'b1111);
    chk("shl_msb", {31'b0, ser_out_msb}, 1);
    after_done();
    ser_in_right = 1'b0;

    // Shift right with il=0: 1000 -> 0100 -> 0010 -> 0001.
    run_cmd(1'b1, 4'b1000, 3'b010, 4'd3, 1'b0, lat, bcyc);
    chk("shr_step1", {28'b0, trace[1]}, 4'b0100);
    chk("shr_step2", {28'b0, trace[2]}, 4'b0010);
    chk("shr_step3", {28'b0, trace[3]}, 4'b0001);
    chk("shr_lsb", {31'b0, ser_out_lsb}, 1);
    after_done();
    // Rotate right without load: 0001 -> 1000.
    run_cmd(1'b0, 4'b1111, 3'b110, 4'd1, 1'b0, lat, bcyc);
    chk("rotr_noload", {28'b0, reg_q}, 4'b1000);
    after_done();

    // Count 0: load visible, done right after accept edge.
    run_cmd(1'b1, 4'b0110, 3'b101, 4'd0, 1'b0, lat, bcyc);
    chk("cnt0_reg", {28'b0, reg_q}, 4'b0110);
    chk("cnt0_lat", lat, 0);
    after_done();
    // Clear without load.
    run_cmd(1'b0, 4'b1111, 3'b011, 4'd1, 1'b0, lat, bcyc);
    chk("clear_reg", {28'b0, reg_q}, 4'b0000);
    after_done();

    // Op 111 holds for full count; pending command waits for IDLE.
    run_cmd(1'b1, 4'b1010, 3'b111, 4'd3, 1'b1, lat, bcyc);
    chk("op7_reg", {28'b0, reg_q}, 4'b1010);
    chk("op7_busy_cyc", bcyc, 4);
    chk("op7_lat", lat, 3);
    @(posedge clk); #1;
    chk("op7_idle_ready", {31'b0, cmd_ready}, 1);
    chk("op7_not_early", {28'b0, reg_q}, 4'b1010);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("op7_pending_done", {31'b0, done}, 1);
    chk("op7_pending_reg", {28'b0, reg_q}, 4'b0101);
    after_done();

    // Reset in the middle of a 15-step shift.
    @(negedge clk);
    cmd_load = 1'b1; cmd_data = 4'b1111; cmd_op = 3'b001; cmd_count = 4'd15; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_step3", {28'b0, reg_q}, 4'b1000);
    chk("mid_sel", {29'b0, sh_select}, 3'b001);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_reg", {28'b0, reg_q}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_ready", {31'b0, cmd_ready}, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", {31'b0, done}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmd_load = 1'b1; cmd_data = 4'b0011; cmd_op = 3'b000; cmd_count = 4'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("post_rst_done", {31'b0, done}, 1);
    chk("post_rst_reg", {28'b0, reg_q}, 4'b0011);
    after_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
